// File: rtl/ahb_slave_mem.sv
// AHB-Lite responder over a word-organised memory: OKAY data phase after WAIT_STATES stalls, two-cycle ERROR.
// New address phases are taken only in IDLE, DATA or ERR2 (hreadyout high); WAIT and ERR1 hold the bus.
module ahb_slave_mem #(
    parameter int          DEPTH       = 256,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic        clk,
    input  logic        hreset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [31:0] hwdata,
    input  logic        hreadyin,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hrdata
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          write_q, write_d;
    logic [3:0]    strb_q, strb_d;
    logic [31:0]   prev_addr_q, prev_addr_d;
    logic [31:0]   mem [DEPTH];

    logic [31:0] offset;
    logic [31:0] incr;
    logic [31:0] wrap_mask;
    logic [31:0] seq_addr;
    logic        wrap;
    logic        sample;
    logic        err;
    logic [3:0]  strb;

    assign offset = haddr - BASE_ADDR;
    assign incr   = 32'd1 << hsize;
    assign sample = hsel && hreadyin && htrans[1] &&
                    (state_q == ST_IDLE || state_q == ST_DATA || state_q == ST_ERR2);

    // Expected SEQ address: previous beat plus transfer size, folded inside the wrap window.
    always_comb begin
        wrap      = 1'b0;
        wrap_mask = '0;
        case (hburst)
            3'b010: begin wrap = 1'b1; wrap_mask = (incr << 2) - 32'd1; end
            3'b100: begin wrap = 1'b1; wrap_mask = (incr << 3) - 32'd1; end
            3'b110: begin wrap = 1'b1; wrap_mask = (incr << 4) - 32'd1; end
            default: ;
        endcase
        seq_addr = wrap ? ((prev_addr_q & ~wrap_mask) | ((prev_addr_q + incr) & wrap_mask))
                        : (prev_addr_q + incr);
    end

    always_comb begin
        err = (offset >= 32'(DEPTH * 4)) || (hsize > 3'd2);
        if (hsize == 3'd1 && haddr[0])
            err = 1'b1;
        if (hsize == 3'd2 && haddr[1:0] != 2'b00)
            err = 1'b1;
        if (htrans == 2'b11 && haddr != seq_addr)
            err = 1'b1;
    end

    always_comb begin
        case (hsize)
            3'd0:    strb = 4'b0001 << haddr[1:0];
            3'd1:    strb = haddr[1] ? 4'b1100 : 4'b0011;
            default: strb = 4'b1111;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        write_d     = write_q;
        strb_d      = strb_q;
        prev_addr_d = prev_addr_q;
        case (state_q)
            ST_WAIT: begin
                if (cnt_q == 4'd0)
                    state_d = ST_DATA;
                else
                    cnt_d = cnt_q - 4'd1;
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
        if (sample) begin
            prev_addr_d = haddr;
            idx_d       = offset[AW+1:2];
            write_d     = hwrite;
            strb_d      = strb;
            if (err) begin
                state_d = ST_ERR1;
            end else if (WAIT_STATES > 0) begin
                state_d = ST_WAIT;
                cnt_d   = 4'(WAIT_STATES - 1);
            end else begin
                state_d = ST_DATA;
            end
        end
    end

    always_ff @(posedge clk or posedge hreset) begin
        if (hreset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            write_q     <= 1'b0;
            strb_q      <= '0;
            prev_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            write_q     <= write_d;
            strb_q      <= strb_d;
            prev_addr_q <= prev_addr_d;
        end
    end

    // Storage is deliberately not reset; a reset moves the FSM out of DATA so pending writes drop.
    always_ff @(posedge clk) begin
        if (state_q == ST_DATA && write_q) begin
            for (int b = 0; b < 4; b++) begin
                if (strb_q[b])
                    mem[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
            end
        end
    end

    assign hreadyout = !(state_q == ST_WAIT || state_q == ST_ERR1);
    assign hresp     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
    assign hrdata    = (state_q == ST_DATA) ? mem[idx_q] : 32'h0;
endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench: three responders (0, 2, 3 wait states) share one bus; a pipelined master drives transfer lists
// and each data phase is checked against a byte-level memory model and the address/alignment rules.
module tb_ahb_slave_mem;
    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [1:0]  trans;
        logic [2:0]  burst;
        logic [31:0] wdata;
    } xfer_t;

    logic        clk = 1'b0;
    logic        hreset;
    logic        hsel_bus;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic        hreadyin;
    logic [1:0]  sel;
    logic        hsel_v   [3];
    logic        hready_o [3];
    logic        hresp_o  [3];
    logic [31:0] hrdata_o [3];
    logic        hresp_cur;
    logic [31:0] hrdata_cur;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          ws_of [3] = '{0, 2, 3};
    logic [7:0]  ref_b [3][1024];
    bit          ref_v [3][1024];
    logic [31:0] ref_prev [3];
    xfer_t       xq [$];
    logic [31:0] last_rdata;

    always #5 clk = ~clk;

    assign hreadyin   = (sel == 2'd0) ? hready_o[0] : (sel == 2'd1) ? hready_o[1] : hready_o[2];
    assign hresp_cur  = (sel == 2'd0) ? hresp_o[0]  : (sel == 2'd1) ? hresp_o[1]  : hresp_o[2];
    assign hrdata_cur = (sel == 2'd0) ? hrdata_o[0] : (sel == 2'd1) ? hrdata_o[1] : hrdata_o[2];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign hsel_v[g] = hsel_bus && (sel == 2'(g));
        ahb_slave_mem #(
            .DEPTH(256),
            .WAIT_STATES((g == 0) ? 0 : g + 1),
            .BASE_ADDR(32'h0)
        ) u_dut (
            .clk(clk),
            .hreset(hreset),
            .hsel(hsel_v[g]),
            .haddr(haddr),
            .htrans(htrans),
            .hwrite(hwrite),
            .hsize(hsize),
            .hburst(hburst),
            .hwdata(hwdata),
            .hreadyin(hreadyin),
            .hreadyout(hready_o[g]),
            .hresp(hresp_o[g]),
            .hrdata(hrdata_o[g])
        );
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic xfer_t mk(input logic [31:0] a, input logic wr, input logic [2:0] sz,
                                 input logic [1:0] tr, input logic [2:0] bu, input logic [31:0] wd);
        xfer_t t;
        t.addr = a; t.wr = wr; t.size = sz; t.trans = tr; t.burst = bu; t.wdata = wd;
        return t;
    endfunction

    // Error rules: out of range, oversize, misaligned, or a SEQ beat that does not follow its predecessor.
    function automatic bit model_err(input int inst, input xfer_t t);
        longint unsigned a    = {32'h0, t.addr};
        longint unsigned sz   = 64'd1 << t.size;
        longint unsigned prev = {32'h0, ref_prev[inst]};
        longint unsigned beats, span, base, exp_a;
        bit e = 1'b0;
        if (a >= 64'd1024) e = 1'b1;
        if (t.size > 3'd2) e = 1'b1;
        else if (a % sz != 64'd0) e = 1'b1;
        if (t.trans == 2'b11) begin
            case (t.burst)
                3'b010:  beats = 64'd4;
                3'b100:  beats = 64'd8;
                3'b110:  beats = 64'd16;
                default: beats = 64'd0;
            endcase
            if (beats == 64'd0) begin
                exp_a = prev + sz;
            end else begin
                span  = sz * beats;
                base  = (prev / span) * span;
                exp_a = base + (prev - base + sz) % span;
            end
            if (exp_a[31:0] != t.addr) e = 1'b1;
        end
        return e;
    endfunction

    function automatic bit model_word(input int inst, input logic [31:0] addr, output logic [31:0] w);
        int base = int'(addr[9:2]) * 4;
        bit ok = 1'b1;
        w = '0;
        for (int i = 0; i < 4; i++) begin
            ok = ok && ref_v[inst][base + i];
            w[8*i +: 8] = ref_b[inst][base + i];
        end
        return ok;
    endfunction

    task automatic model_write(input int inst, input xfer_t t);
        int b;
        for (int i = 0; i < (1 << t.size); i++) begin
            b = int'(t.addr[9:0]) + i;
            ref_b[inst][b] = t.wdata[8*(b % 4) +: 8];
            ref_v[inst][b] = 1'b1;
        end
    endtask

    // Pipelined master: address of transfer a overlaps the data phase of transfer d.
    task automatic run_xfers();
        int n = xq.size();
        int inst = int'(sel);
        int a = 0;
        int d = -1;
        int cyc = 0;
        int nwait = 0;
        int budget = 0;
        bit d_act = 1'b0;
        bit d_err = 1'b0;
        bit first_resp = 1'b0;
        bit resp_any = 1'b0;
        bit hr;
        bit wv;
        logic [31:0] w;
        while ((a < n || d >= 0) && budget < 4000) begin
            budget++;
            if (a < n) begin
                hsel_bus = 1'b1; haddr = xq[a].addr; htrans = xq[a].trans;
                hwrite = xq[a].wr; hsize = xq[a].size; hburst = xq[a].burst;
            end else begin
                hsel_bus = 1'b0; haddr = $urandom; htrans = 2'b00;
                hwrite = 1'b0; hsize = 3'd0; hburst = 3'd0;
            end
            hwdata = (d >= 0 && hreadyin) ? xq[d].wdata : $urandom;
            @(negedge clk);
            hr = hreadyin;
            if (d >= 0) begin
                cyc++;
                if (!hr) nwait++;
                if (cyc == 1) first_resp = hresp_cur;
                resp_any = resp_any | hresp_cur;
                if (hr) begin
                    if (!d_act) begin
                        chk("idle_waits", 64'(nwait), 64'd0);
                        chk("idle_resp", 64'(resp_any), 64'd0);
                        chk("idle_rdata", 64'(hrdata_cur), 64'd0);
                    end else if (d_err) begin
                        chk("err_waits", 64'(nwait), 64'd1);
                        chk("err_resp_seq", {62'd0, first_resp, hresp_cur}, 64'd3);
                    end else begin
                        chk("okay_waits", 64'(nwait), 64'(ws_of[inst]));
                        chk("okay_resp", 64'(resp_any), 64'd0);
                        if (xq[d].wr) begin
                            model_write(inst, xq[d]);
                        end else begin
                            last_rdata = hrdata_cur;
                            wv = model_word(inst, xq[d].addr, w);
                            if (wv) chk("rdata", 64'(hrdata_cur), 64'(w));
                        end
                    end
                end
            end
            @(posedge clk);
            if (hr) begin
                d = -1;
                if (a < n) begin
                    d = a; d_act = xq[a].trans[1]; d_err = 1'b0;
                    cyc = 0; nwait = 0; resp_any = 1'b0; first_resp = 1'b0;
                    if (d_act) begin
                        d_err = model_err(inst, xq[a]);
                        ref_prev[inst] = xq[a].addr;
                    end
                    a++;
                end
            end
            #1;
        end
        chk("no_timeout", 64'(budget < 4000), 64'd1);
        xq.delete();
    endtask

    task automatic gen_random(input int items);
        int kind, len, bad;
        logic [2:0] sz, bu;
        logic [31:0] a, m, sm;
        logic [31:0] ad [8];
        for (int k = 0; k < items; k++) begin
            kind = $urandom_range(0, 9);
            sz = 3'($urandom_range(0, 2));
            m = (32'd1 << sz) - 32'd1;
            if (kind < 4) begin
                a = 32'($urandom_range(0, 127)) & ~m;
                if ($urandom_range(0, 11) == 0) a = 32'h400 + 32'($urandom_range(0, 1023));
                if ($urandom_range(0, 11) == 0) a = a | 32'd1;
                if ($urandom_range(0, 15) == 0) sz = 3'd3;
                xq.push_back(mk(a, 1'($urandom), sz, 2'b10, 3'b000, $urandom));
            end else if (kind < 6) begin
                xq.push_back(mk($urandom, 1'($urandom), sz, 2'($urandom_range(0, 1)), 3'b000, $urandom));
            end else begin
                if (kind < 8) begin
                    bu = 3'b001; len = $urandom_range(2, 6);
                    a = 32'($urandom_range(0, 96)) & ~m;
                    for (int i = 0; i < len; i++) ad[i] = a + (32'(i) << sz);
                end else begin
                    bu = 3'b010; len = 4;
                    a = 32'($urandom_range(0, 127)) & ~m;
                    sm = (m << 2) | 32'd3;
                    for (int i = 0; i < len; i++) ad[i] = (a & ~sm) | ((a + (32'(i) << sz)) & sm);
                end
                bad = ($urandom_range(0, 7) == 0) ? $urandom_range(1, len - 1) : 0;
                for (int pass = 0; pass < 2; pass++) begin
                    for (int i = 0; i < len; i++) begin
                        if (i > 0 && $urandom_range(0, 5) == 0)
                            xq.push_back(mk(ad[i], pass == 0, sz, 2'b01, bu, 32'h0));
                        xq.push_back(mk((pass == 0 && bad != 0 && i == bad) ? ad[i] + 32'd4 : ad[i],
                                        pass == 0, sz, (i == 0) ? 2'b10 : 2'b11, bu, $urandom));
                    end
                end
            end
        end
    endtask

    initial begin
        hreset = 1'b1; hsel_bus = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
        hsize = 3'd0; hburst = 3'd0; hwdata = '0; sel = 2'd0; last_rdata = '0;
        for (int i = 0; i < 3; i++) ref_prev[i] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_hreadyout", 64'(hready_o[i]), 64'd1);
            chk("rst_hresp", 64'(hresp_o[i]), 64'd0);
            chk("rst_hrdata", 64'(hrdata_o[i]), 64'd0);
        end
        hreset = 1'b0;
        @(posedge clk); #1;

        // Single write then read, zero wait
        sel = 2'd0;
        xq.push_back(mk(32'h4, 1'b1, 3'd2, 2'b10, 3'b000, 32'hDEAD_BEEF));
        xq.push_back(mk(32'h4, 1'b0, 3'd2, 2'b10, 3'b000, 32'h0));
        run_xfers();
        chk("single_rd", 64'(last_rdata), 64'h0000_0000_DEAD_BEEF);

        // INCR write and read-back
        for (int i = 0; i < 4; i++)
            xq.push_back(mk(32'h10 + 32'(4 * i), 1'b1, 3'd2, (i == 0) ? 2'b10 : 2'b11, 3'b001, 32'(i + 1)));
        for (int i = 0; i < 4; i++)
            xq.push_back(mk(32'h10 + 32'(4 * i), 1'b0, 3'd2, (i == 0) ? 2'b10 : 2'b11, 3'b001, 32'h0));
        run_xfers();
        chk("incr_last_rd", 64'(last_rdata), 64'd4);

        // Two wait states; hwdata is scrambled during the stall
        sel = 2'd1;
        xq.push_back(mk(32'h8, 1'b1, 3'd2, 2'b10, 3'b000, 32'h0BAD_F00D));
        xq.push_back(mk(32'h8, 1'b0, 3'd2, 2'b10, 3'b000, 32'h0));
        run_xfers();
        chk("wait2_rd", 64'(last_rdata), 64'h0000_0000_0BAD_F00D);

        // Byte and halfword lane merges
        sel = 2'd0;
        xq.push_back(mk(32'h20, 1'b1, 3'd2, 2'b10, 3'b000, 32'h1122_3344));
        xq.push_back(mk(32'h21, 1'b1, 3'd0, 2'b10, 3'b000, 32'h0000_AA00));
        xq.push_back(mk(32'h20, 1'b0, 3'd2, 2'b10, 3'b000, 32'h0));
        run_xfers();
        chk("byte_merge", 64'(last_rdata), 64'h0000_0000_1122_AA44);
        xq.push_back(mk(32'h22, 1'b1, 3'd1, 2'b10, 3'b000, 32'h5566_0000));
        xq.push_back(mk(32'h20, 1'b0, 3'd2, 2'b10, 3'b000, 32'h0));
        run_xfers();
        chk("half_merge", 64'(last_rdata), 64'h0000_0000_5566_AA44);

        // Out-of-range and misaligned accesses leave word 0 intact
        xq.push_back(mk(32'h0, 1'b1, 3'd2, 2'b10, 3'b000, 32'h0102_0304));
        xq.push_back(mk(32'h400, 1'b0, 3'd2, 2'b10, 3'b000, 32'h0));
        xq.push_back(mk(32'h400, 1'b1, 3'd2, 2'b10, 3'b000, 32'hFFFF_FFFF));
        xq.push_back(mk(32'h2, 1'b1, 3'd2, 2'b10, 3'b000, 32'hFFFF_FFFF));
        xq.push_back(mk(32'h0, 1'b0, 3'd2, 2'b10, 3'b000, 32'h0));
        run_xfers();
        chk("err_mem_kept", 64'(last_rdata), 64'h0000_0000_0102_0304);

        // Reset asserted while a write is stalled
        sel = 2'd2;
        xq.push_back(mk(32'h40, 1'b1, 3'd2, 2'b10, 3'b000, 32'hCAFE_0001));
        run_xfers();
        hsel_bus = 1'b1; haddr = 32'h40; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2; hburst = 3'd0;
        hwdata = $urandom;
        @(posedge clk); #1;
        hsel_bus = 1'b0; htrans = 2'b00; hwdata = 32'h1234_5678;
        @(negedge clk);
        chk("mid_wait_stall", 64'(hreadyin), 64'd0);
        #1 hreset = 1'b1;
        #1;
        chk("async_rst_ready", 64'(hreadyin), 64'd1);
        chk("async_rst_resp", 64'(hresp_cur), 64'd0);
        chk("async_rst_rdata", 64'(hrdata_cur), 64'd0);
        for (int i = 0; i < 3; i++) ref_prev[i] = '0;
        repeat (2) @(posedge clk);
        #1 hreset = 1'b0;
        xq.push_back(mk(32'h40, 1'b1, 3'd2, 2'b00, 3'b000, 32'h0));
        xq.push_back(mk(32'h40, 1'b1, 3'd2, 2'b01, 3'b000, 32'h0));
        xq.push_back(mk(32'h40, 1'b0, 3'd2, 2'b10, 3'b000, 32'h0));
        run_xfers();
        chk("rst_write_dropped", 64'(last_rdata), 64'h0000_0000_CAFE_0001);

        // Randomized mixed traffic on every wait-state variant
        for (int inst = 0; inst < 3; inst++) begin
            sel = 2'(inst);
            gen_random(30);
            run_xfers();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
